// File: rtl/frame_decoder_if.sv
// Link-side and message-side signals of frame_decoder, grouped as one bundle.
// slave = decoder, master = symbol source / message consumer.
interface frame_decoder_if #(
  parameter int PACKET_SIZE = 8,
  parameter int MESSAGE_BIT = 256,
  parameter int CHANNEL_BIT = 1
);
  logic                   in_valid;
  logic [PACKET_SIZE-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [CHANNEL_BIT-1:0] out_channel;
  logic [4:0]             out_length;
  logic [MESSAGE_BIT-1:0] out_data;
  logic                   out_ready;
  logic                   drop_pulse;
  logic [7:0]             err_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_channel, out_length, out_data, drop_pulse, err_count
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_channel, out_length, out_data, drop_pulse, err_count
  );
endinterface

// File: rtl/frame_decoder.sv
// Symbol-stream frame decoder: HEAD, CHAN, LEN, DATA..., END -> one held message.
// Optional saturating drop counter enabled by `define FRAME_DECODER_ERR_COUNT_EN.
module frame_decoder #(
  parameter int PACKET_SIZE = 8,
  parameter int MESSAGE_BIT = 256,
  parameter int CHANNEL_BIT = 1
) (
  input logic           CLK,
  input logic           RST_N,
  frame_decoder_if.slave bus
);
  localparam int SYM_W = PACKET_SIZE - 1;

  typedef enum logic [2:0] {S_IDLE, S_CHAN, S_LEN, S_DATA, S_END, S_HOLD} state_t;
  state_t st, nxt;

  logic [4:0]             id_q, len_q;
  logic [CHANNEL_BIT-1:0] chan_q;
  logic [8:0]             ptr_q;
  logic [MESSAGE_BIT-1:0] payload_q;
  logic [CHANNEL_BIT-1:0] och_q;
  logic [4:0]             olen_q;
  logic [MESSAGE_BIT-1:0] odata_q;
  logic                   drop_q;

  logic [2:0]       cls;
  logic [SYM_W-1:0] sym;
  logic             is_head, is_chan, is_len, is_end, is_data, acc, last_data;
  logic             start, drop, take_chan, take_len, take_data, load;

  assign cls     = bus.in_data[PACKET_SIZE-1 -: 3];
  assign sym     = bus.in_data[SYM_W-1:0];
  assign is_data = ~bus.in_data[PACKET_SIZE-1];
  assign is_head = (cls == 3'b100);
  assign is_chan = (cls == 3'b101);
  assign is_len  = (cls == 3'b110);
  assign is_end  = (cls == 3'b111);
  assign acc     = bus.in_valid && (st != S_HOLD);
  // Last DATA symbol once this one reaches length*8 bits (pre-update pointer).
  assign last_data = ({1'b0, ptr_q} + 10'(SYM_W)) >= {2'b00, len_q, 3'b000};

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) st <= S_IDLE;
    else        st <= nxt;

  always_comb begin
    nxt       = st;
    start     = 1'b0;
    drop      = 1'b0;
    take_chan = 1'b0;
    take_len  = 1'b0;
    take_data = 1'b0;
    load      = 1'b0;
    case (st)
      S_IDLE: if (acc && is_head) begin start = 1'b1; nxt = S_CHAN; end
      S_CHAN: if (acc) begin
        if (is_chan) begin take_chan = 1'b1; nxt = S_LEN; end
        else drop = 1'b1;
      end
      S_LEN: if (acc) begin
        if (is_len) begin take_len = 1'b1; nxt = S_DATA; end
        else drop = 1'b1;
      end
      S_DATA: if (acc) begin
        if (is_data) begin
          take_data = 1'b1;
          if (last_data) nxt = S_END;
        end else drop = 1'b1;
      end
      S_END: if (acc) begin
        if (is_end && (bus.in_data[4:0] == id_q)) begin load = 1'b1; nxt = S_HOLD; end
        else drop = 1'b1;
      end
      S_HOLD: if (bus.out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // An aborting HEAD opens the next frame in the same cycle.
    if (drop) begin
      start = is_head;
      nxt   = is_head ? S_CHAN : S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      id_q      <= '0;
      len_q     <= '0;
      chan_q    <= '0;
      ptr_q     <= '0;
      payload_q <= '0;
      och_q     <= '0;
      olen_q    <= '0;
      odata_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= drop;
      if (start) begin
        id_q      <= bus.in_data[4:0];
        payload_q <= '0;
        ptr_q     <= '0;
      end
      if (take_chan) chan_q <= bus.in_data[CHANNEL_BIT-1:0];
      if (take_len)  len_q  <= bus.in_data[4:0];
      // Payload starts cleared and fills upward, so OR-in is a write; bits past the top fall off.
      if (take_data) begin
        payload_q <= payload_q | (MESSAGE_BIT'(sym) << ptr_q);
        ptr_q     <= ptr_q + 9'(SYM_W);
      end
      if (load) begin
        och_q   <= chan_q;
        olen_q  <= len_q;
        odata_q <= payload_q;
      end
    end

  assign bus.in_ready    = (st != S_HOLD);
  assign bus.out_valid   = (st == S_HOLD);
  assign bus.out_channel = och_q;
  assign bus.out_length  = olen_q;
  assign bus.out_data    = odata_q;
  assign bus.drop_pulse  = drop_q;

`ifdef FRAME_DECODER_ERR_COUNT_EN
  logic [7:0] err_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)                      err_q <= '0;
    else if (drop && err_q != 8'hFF) err_q <= err_q + 8'd1;
  assign bus.err_count = err_q;
`else
  assign bus.err_count = 8'h00;
`endif
endmodule

// File: tb/tb_frame_decoder.sv
// Bench for frame_decoder: directed frames with literal expectations plus
// random frames, all checked every cycle against a frame-level model.
module tb_frame_decoder;
  localparam int P = 8, MB = 256, CB = 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  frame_decoder_if #(.PACKET_SIZE(P), .MESSAGE_BIT(MB), .CHANNEL_BIT(CB)) bus();
  frame_decoder #(.PACKET_SIZE(P), .MESSAGE_BIT(MB), .CHANNEL_BIT(CB)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus));

  int checks = 0, errors = 0;
  int drop_seen = 0, hs_seen = 0;
  bit rand_rdy = 0;

  task automatic chk(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit                m_hold, m_drop;
  int                m_err;
  logic [CB-1:0]     m_ch;
  logic [4:0]        m_len;
  logic [MB-1:0]     m_data;
  int                f_stage;   // 0 none, 1 want chan, 2 want len, 3 payload, 4 want end
  logic [4:0]        f_id, f_len;
  logic [CB-1:0]     f_ch;
  bit                fbits[$];

  task automatic model_sym(input logic [P-1:0] s);
    logic [2:0] c;
    bit ok;
    c  = s[P-1 -: 3];
    ok = 0;
    case (f_stage)
      1: ok = (c == 3'b101);
      2: ok = (c == 3'b110);
      3: ok = !s[P-1];
      4: ok = (c == 3'b111) && (s[4:0] == f_id);
      default: ok = 0;
    endcase
    if (f_stage != 0 && !ok) begin
      m_drop = 1;
      if (m_err < 255) m_err++;
      f_stage = 0;
    end
    if (f_stage == 0) begin
      if (c == 3'b100) begin f_stage = 1; f_id = s[4:0]; fbits.delete(); end
      return;
    end
    case (f_stage)
      1: begin f_ch = s[CB-1:0]; f_stage = 2; end
      2: begin f_len = s[4:0]; f_stage = 3; end
      3: begin
        for (int i = 0; i < P-1; i++) fbits.push_back(s[i]);
        if (fbits.size() >= 8*f_len) f_stage = 4;
      end
      default: begin
        m_data = '0;
        foreach (fbits[i]) if (i < MB) m_data[i] = fbits[i];
        m_ch = f_ch; m_len = f_len; m_hold = 1; f_stage = 0;
      end
    endcase
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_hold = 0; m_drop = 0; m_err = 0; f_stage = 0; fbits.delete();
      m_ch = '0; m_len = '0; m_data = '0;
    end else begin
      m_drop = 0;
      if (m_hold) begin
        if (bus.out_ready) m_hold = 0;
      end else if (bus.in_valid) model_sym(bus.in_data);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    logic [7:0] exp_err;
`ifdef FRAME_DECODER_ERR_COUNT_EN
    exp_err = 8'(m_err);
`else
    exp_err = 8'h00;
`endif
    chk("in_ready", bus.in_ready, !m_hold);
    chk("out_valid", bus.out_valid, m_hold);
    chk("drop_pulse", bus.drop_pulse, m_drop);
    chk("err_count", bus.err_count, exp_err);
    if (m_hold) begin
      chk("out_channel", bus.out_channel, m_ch);
      chk("out_length", bus.out_length, m_len);
      chk("out_data", bus.out_data, m_data);
    end
    if (bus.drop_pulse) drop_seen++;
    if (bus.out_valid && bus.out_ready) hs_seen++;
  end

  always @(posedge CLK) if (rand_rdy) begin
    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [P-1:0] s);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = s;
    @(negedge CLK);
    while (!bus.in_ready && n < 200) begin @(negedge CLK); n++; end
    chk("send_ready", bus.in_ready, 1'b1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    @(negedge CLK);
    while (!bus.out_valid && n < 50) begin @(negedge CLK); n++; end
    chk(name, bus.out_valid, 1'b1);
  endtask

  task automatic send_frame(input logic [P-1:0] end_sym);
    send(8'h81); send(8'hA1); send(8'hC1); send(8'h55); send(8'h01); send(end_sym);
  endtask

  task automatic rand_frame();
    logic [P-1:0] q[$];
    logic [P-1:0] s;
    logic [4:0]   id, len;
    int           nd;
    id  = 5'($urandom);
    len = 5'($urandom);
    if ($urandom_range(0, 7) == 0) q.push_back(P'($urandom));
    q.push_back({3'b100, id});
    s = P'($urandom); s[P-1 -: 3] = 3'b101; q.push_back(s);
    q.push_back({3'b110, len});
    nd = (len == 0) ? 1 : (8*len + 6) / 7;
    for (int i = 0; i < nd; i++) q.push_back({1'b0, 7'($urandom)});
    if ($urandom_range(0, 5) == 0) q.push_back({3'b111, id ^ 5'(1 + $urandom_range(0, 30))});
    else                           q.push_back({3'b111, id});
    if ($urandom_range(0, 5) == 0) q[$urandom_range(0, q.size()-1)] = P'($urandom);
    foreach (q[i]) begin
      send(q[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, d0, h0;
    logic [7:0] e_err;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_len", bus.out_length, 5'd0);
    chk("rst_err", bus.err_count, 8'h00);
    @(posedge CLK); #1;

    // Basic frame, consumer always ready
    d0 = drop_seen; h0 = hs_seen;
    send_frame(8'hE1);
    wait_valid("f1_valid", n);
    chk("f1_latency", n, 0);
    chk("f1_chan", bus.out_channel, 1'b1);
    chk("f1_len", bus.out_length, 5'd1);
    chk("f1_data", bus.out_data[13:0], 14'h00D5);
    @(negedge CLK);
    chk("f1_valid_fall", bus.out_valid, 1'b0);
    chk("f1_hs", hs_seen - h0, 1);
    chk("f1_nodrop", drop_seen - d0, 0);
    @(posedge CLK); #1;

    // Wrong END id
    d0 = drop_seen; h0 = hs_seen;
    send_frame(8'hE2);
    idle(3);
    chk("f2_drop", drop_seen - d0, 1);
    chk("f2_nohs", hs_seen - h0, 0);
`ifdef FRAME_DECODER_ERR_COUNT_EN
    e_err = 8'd1;
`else
    e_err = 8'd0;
`endif
    chk("f2_err", bus.err_count, e_err);

    // Back-pressure for 5 cycles, link keeps offering a symbol meanwhile
    bus.out_ready = 1'b0;
    send_frame(8'hE1);
    wait_valid("f3_valid", n);
    bus.in_valid = 1'b1; bus.in_data = 8'h85;
    for (int i = 0; i < 5; i++) begin
      chk("f3_in_ready_low", bus.in_ready, 1'b0);
      chk("f3_data_stable", bus.out_data[13:0], 14'h00D5);
      @(negedge CLK);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("f3_in_ready_back", bus.in_ready, 1'b1);
    chk("f3_valid_gone", bus.out_valid, 1'b0);
    @(posedge CLK); #1;

    // HEAD aborts a frame and restarts as id 3
    d0 = drop_seen;
    send(8'h81); send(8'hA0); send(8'h83); send(8'hA1); send(8'hC1);
    send(8'h55); send(8'h01); send(8'hE3);
    wait_valid("f4_valid", n);
    chk("f4_data", bus.out_data[13:0], 14'h00D5);
    chk("f4_chan", bus.out_channel, 1'b1);
    chk("f4_drop", drop_seen - d0, 1);
    @(posedge CLK); #1;

    // Reset mid-payload, then a fresh 2-byte frame of all-ones payload
    send(8'h81); send(8'hA1); send(8'hC4); send(8'h55);
    #2 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    d0 = drop_seen; h0 = hs_seen;
    chk("f5_err_rst", bus.err_count, 8'h00);
    send(8'h82); send(8'hA0); send(8'hC2);
    send(8'h7F); send(8'h7F); send(8'h7F); send(8'hE2);
    wait_valid("f5_valid", n);
    chk("f5_chan", bus.out_channel, 1'b0);
    chk("f5_len", bus.out_length, 5'd2);
    chk("f5_data", bus.out_data, 256'h1FFFFF);
    @(negedge CLK);
    chk("f5_hs", hs_seen - h0, 1);
    chk("f5_nodrop", drop_seen - d0, 0);
    @(posedge CLK); #1;

    // Random frames with corruption and random consumer stalls
    rand_rdy = 1;
    for (int f = 0; f < 150; f++) rand_frame();
    rand_rdy = 0;
    @(posedge CLK); #2;
    bus.out_ready = 1'b1;
    idle(4);
    #2 RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Drop counter saturation
    d0 = drop_seen;
    for (int f = 0; f < 300; f++) begin send(8'h81); send(8'h00); end
    idle(2);
    chk("f6_drops", drop_seen - d0, 300);
`ifdef FRAME_DECODER_ERR_COUNT_EN
    e_err = 8'hFF;
`else
    e_err = 8'h00;
`endif
    chk("f6_err_sat", bus.err_count, e_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
